// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI-style read path (AR + R channels) between
// requester 0 (i_cache) and requester 1 (d_cache). One burst is in flight at
// a time; ties are broken round-robin against the previous owner.
// Optional build macro MEM_READ_ARB_PERF_EN adds saturating grant/wait counters.
//
// state | meaning
// IDLE  | no burst owned; arbitrate pending requests
// ADDR  | owner's AR forwarded to memory, waiting for s_arready
// DATA  | routing R beats to the owner until burst end
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_arvalid,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic [ID_WIDTH-1:0]   m0_arid,
    output logic                  m0_arready,
    input  logic                  m1_arvalid,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic [ID_WIDTH-1:0]   m1_arid,
    output logic                  m1_arready,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    input  logic                  m0_rready,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  s_arvalid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic [ID_WIDTH-1:0]   s_arid,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rlast,
    output logic                  s_rready,
    output logic                  busy,
    output logic                  grant,
    output logic                  len_err
`ifdef MEM_READ_ARB_PERF_EN
    ,
    output logic [31:0]           perf_grants0,
    output logic [31:0]           perf_grants1,
    output logic [31:0]           perf_wait0,
    output logic [31:0]           perf_wait1
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state;
    logic                 last_grant;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] beat_cnt;

    logic in_addr;
    logic in_data;
    logic ar_hs;
    logic r_hs;
    logic cnt_last;
    logic burst_end;
    logic next_owner;

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    // Handshake and burst-end detection; beat_cnt never wraps since len <= 16
    assign ar_hs      = in_addr && s_arready;
    assign r_hs       = in_data && s_rvalid && s_rready;
    assign cnt_last   = ((beat_cnt + LEN_ONE) == len_reg);
    assign burst_end  = r_hs && (s_rlast || cnt_last);
    assign next_owner = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;

    // Channel routing; all valid/ready outputs decode from the async-reset state
    assign busy       = (state != IDLE);
    assign s_arvalid  = in_addr;
    assign s_araddr   = grant ? m1_araddr : m0_araddr;
    assign s_arlen    = grant ? m1_arlen  : m0_arlen;
    assign s_arid     = grant ? m1_arid   : m0_arid;
    assign m0_arready = in_addr && !grant && s_arready;
    assign m1_arready = in_addr &&  grant && s_arready;
    assign s_rready   = in_data && (grant ? m1_rready : m0_rready);
    assign m0_rvalid  = in_data && !grant && s_rvalid;
    assign m1_rvalid  = in_data &&  grant && s_rvalid;
    assign m_rdata    = s_rdata;

    // Arbitration FSM with burst tracking and sticky length-error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            len_reg    <= '0;
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        grant    <= next_owner;
                        len_reg  <= next_owner ? m1_arlen : m0_arlen;
                        beat_cnt <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        last_grant <= grant;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                    end
                    if (burst_end) begin
                        if (s_rlast != cnt_last) begin
                            len_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_READ_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating grant and wait-cycle counters per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants0 <= '0;
            perf_grants1 <= '0;
            perf_wait0   <= '0;
            perf_wait1   <= '0;
        end else begin
            if (ar_hs && !grant) perf_grants0 <= sat_inc(perf_grants0);
            if (ar_hs &&  grant) perf_grants1 <= sat_inc(perf_grants1);
            if (m0_arvalid && !(in_addr && !grant)) perf_wait0 <= sat_inc(perf_wait0);
            if (m1_arvalid && !(in_addr &&  grant)) perf_wait1 <= sat_inc(perf_wait1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge or just after the
// rising edge for state-only decodes.
module tb_mem_read_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 4;

    localparam logic [AW-1:0] A0 = 26'h0001040;
    localparam logic [AW-1:0] A1 = 26'h2000200;
    localparam logic [LW-1:0] L0 = 8'd4;
    localparam logic [LW-1:0] L1 = 8'd2;
    localparam logic [IW-1:0] I0 = 4'h5;
    localparam logic [IW-1:0] I1 = 4'hA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_arvalid, m1_arvalid;
    logic [AW-1:0] m0_araddr, m1_araddr;
    logic [LW-1:0] m0_arlen, m1_arlen;
    logic [IW-1:0] m0_arid, m1_arid;
    logic          m0_arready, m1_arready;
    logic          m0_rvalid, m1_rvalid;
    logic          m0_rready, m1_rready;
    logic [DW-1:0] m_rdata;
    logic          s_arvalid;
    logic [AW-1:0] s_araddr;
    logic [LW-1:0] s_arlen;
    logic [IW-1:0] s_arid;
    logic          s_arready;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_rlast;
    logic          s_rready;
    logic          busy;
    logic          grant;
    logic          len_err;
`ifdef MEM_READ_ARB_PERF_EN
    logic [31:0]   perf_grants0, perf_grants1, perf_wait0, perf_wait1;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_g0 = 0;
    int exp_g1 = 0;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arid(m0_arid), .m0_arready(m0_arready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arid(m1_arid), .m1_arready(m1_arready),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rready(m0_rready), .m1_rready(m1_rready),
        .m_rdata(m_rdata),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arid(s_arid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rready(s_rready),
        .busy(busy), .grant(grant), .len_err(len_err)
`ifdef MEM_READ_ARB_PERF_EN
        ,
        .perf_grants0(perf_grants0), .perf_grants1(perf_grants1),
        .perf_wait0(perf_wait0), .perf_wait1(perf_wait1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Called at posedge+1 in the cycle the request is visible in IDLE
    task automatic addr_phase(input bit who, input int stall, input bit keep);
        chk("req_cycle_arvalid", 64'(s_arvalid), 64'd0);
        chk("req_cycle_busy", 64'(busy), 64'd0);
        step();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_arvalid", 64'(s_arvalid), 64'd1);
            chk("stall_arready", 64'(who ? m1_arready : m0_arready), 64'd0);
            step();
        end
        s_arready = 1'b1;
        @(negedge clk);
        chk("grant", 64'(grant), 64'(who));
        chk("s_arvalid", 64'(s_arvalid), 64'd1);
        chk("s_araddr", 64'(s_araddr), 64'(who ? A1 : A0));
        chk("s_arlen", 64'(s_arlen), 64'(who ? L1 : L0));
        chk("s_arid", 64'(s_arid), 64'(who ? I1 : I0));
        chk("arready_own", 64'(who ? m1_arready : m0_arready), 64'd1);
        chk("arready_other", 64'(who ? m0_arready : m1_arready), 64'd0);
        chk("rready_in_addr", 64'(s_rready), 64'd0);
        step();
        s_arready = 1'b0;
        if (!keep) begin
            if (who) m1_arvalid = 1'b0;
            else     m0_arvalid = 1'b0;
        end
        if (who) exp_g1++;
        else     exp_g0++;
    endtask

    // Delivers nbeats; rlast on beat rlast_at (1-based, 0 = never)
    task automatic data_phase(input bit who, input int nbeats, input int rlast_at,
                              input int gap, input bit toggle, input bit expect_end);
        bit done;
        logic [DW-1:0] exp_data;
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                s_rvalid = 1'b0;
                @(negedge clk);
                chk("gap_rvalid", 64'(who ? m1_rvalid : m0_rvalid), 64'd0);
                step();
            end
            exp_data = 32'hD000_0000 + (32'(who) << 8) + 32'(b);
            s_rvalid = 1'b1;
            s_rlast  = ((b + 1) == rlast_at);
            s_rdata  = exp_data;
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                if (toggle) begin
                    if (who) m1_rready = (t % 2 == 1);
                    else     m0_rready = (t % 2 == 1);
                end
                @(negedge clk);
                chk("beat_busy", 64'(busy), 64'd1);
                chk("rvalid_own", 64'(who ? m1_rvalid : m0_rvalid), 64'd1);
                chk("rvalid_other", 64'(who ? m0_rvalid : m1_rvalid), 64'd0);
                chk("rready_track", 64'(s_rready), 64'(who ? m1_rready : m0_rready));
                if (who ? m1_rready : m0_rready) begin
                    chk("rdata", 64'(m_rdata), 64'(exp_data));
                    done = 1'b1;
                end
                step();
            end
            if (!done) chk("beat_timeout", 64'd0, 64'd1);
        end
        if (expect_end) begin
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
            m0_rready = 1'b1;
            m1_rready = 1'b1;
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_rready", 64'(s_rready), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_araddr = A0; m0_arlen = L0; m0_arid = I0;
        m1_araddr = A1; m1_arlen = L1; m1_arid = I1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;

        do_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_arvalid", 64'(s_arvalid), 64'd0);

        // m0 alone, len 4, immediate s_arready
        m0_arvalid = 1'b1;
        addr_phase(1'b0, 0, 1'b0);
        data_phase(1'b0, 4, 4, 0, 1'b0, 1'b1);
        chk("t1_len_err", 64'(len_err), 64'd0);

        // simultaneous requests after reset: m1 first, then m0 after one bubble
        do_reset();
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        addr_phase(1'b1, 0, 1'b0);
        data_phase(1'b1, 2, 2, 0, 1'b0, 1'b1);
        addr_phase(1'b0, 0, 1'b0);
        data_phase(1'b0, 4, 4, 0, 1'b0, 1'b1);

        // both held high: grants alternate 1,0,1,0,1,0
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            addr_phase((k % 2) == 0, 0, 1'b1);
            data_phase((k % 2) == 0, ((k % 2) == 0) ? 2 : 4, ((k % 2) == 0) ? 2 : 4,
                       0, 1'b0, 1'b1);
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        step();
        chk("idle_grant_hold", 64'(grant), 64'd0);
        chk("t3_len_err", 64'(len_err), 64'd0);

        // m1 with 5 stall cycles, gapped beats and toggling rready
        m1_arvalid = 1'b1;
        addr_phase(1'b1, 5, 1'b0);
        data_phase(1'b1, 2, 2, 2, 1'b1, 1'b1);
        chk("t4_len_err", 64'(len_err), 64'd0);

        // early rlast on beat 3 of 4: burst ends, len_err sticks
        m0_arvalid = 1'b1;
        addr_phase(1'b0, 0, 1'b0);
        data_phase(1'b0, 3, 3, 0, 1'b0, 1'b1);
        chk("len_err_set", 64'(len_err), 64'd1);
        step(); step(); step();
        chk("len_err_sticky", 64'(len_err), 64'd1);
`ifdef MEM_READ_ARB_PERF_EN
        chk("perf_grants0", 64'(perf_grants0), 64'(exp_g0));
        chk("perf_grants1", 64'(perf_grants1), 64'(exp_g1));
`endif

        // async reset mid-DATA after beat 2 of 4
        m0_arvalid = 1'b1;
        addr_phase(1'b0, 0, 1'b0);
        data_phase(1'b0, 2, 0, 0, 1'b0, 1'b0);
        s_rvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid0", 64'(m0_rvalid), 64'd0);
        chk("arst_rvalid1", 64'(m1_rvalid), 64'd0);
        chk("arst_rready", 64'(s_rready), 64'd0);
        chk("arst_arvalid", 64'(s_arvalid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_len_err", 64'(len_err), 64'd0);
        s_rvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_len_err", 64'(len_err), 64'd0);

        // single-beat burst after reset exercises cleared beat counter
        m0_arlen = 8'd1;
        m0_arvalid = 1'b1;
        chk("req_cycle_arvalid", 64'(s_arvalid), 64'd0);
        step();
        s_arready = 1'b1;
        @(negedge clk);
        chk("len1_arlen", 64'(s_arlen), 64'd1);
        step();
        s_arready = 1'b0;
        m0_arvalid = 1'b0;
        data_phase(1'b0, 1, 1, 0, 1'b0, 1'b1);
        chk("len1_len_err", 64'(len_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
Two-requester arbiter that shares the single AXI-style memory read path (read address + read data channels) between i_cache (requester 0) and d_cache (requester 1).
It grants one burst at a time in round-robin order, forwards the winner's AR request to memory, and routes the returning R beats back to the owner.
It sits between the caches' axi_read_address/axi_read_data masters and the memory-side slave port. The write channels are not handled here.

Parameters:
ADDR_WIDTH, 26, byte-address width of ARADDR.
DATA_WIDTH, 32, RDATA width.
LEN_WIDTH, 8, ARLEN width; ARLEN is a beat count (not count-1), 1..16.
ID_WIDTH, 4, ARID/RID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_arvalid, m1_arvalid  in  1  requester read-address valid.
- m0_araddr, m1_araddr  in  ADDR_WIDTH  requester burst address.
- m0_arlen, m1_arlen  in  LEN_WIDTH  requester beat count.
- m0_arid, m1_arid  in  ID_WIDTH  requester ID, forwarded unchanged.
- m0_arready, m1_arready  out  1  AR accepted.
- m0_rvalid, m1_rvalid  out  1  routed read-data valid.
- m0_rready, m1_rready  in  1  requester read-data ready.
- m_rdata  out  DATA_WIDTH  read data, broadcast to both requesters.
- s_arvalid  out  1  to memory.
- s_araddr  out  ADDR_WIDTH  to memory.
- s_arlen  out  LEN_WIDTH  to memory.
- s_arid  out  ID_WIDTH  to memory.
- s_arready  in  1  from memory.
- s_rvalid  in  1  from memory.
- s_rdata  in  DATA_WIDTH  from memory.
- s_rlast  in  1  from memory.
- s_rready  out  1  to memory.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  current/last owner (0 = m0, 1 = m1).
- len_err  out  1  sticky: s_rlast disagreed with the beat count.

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (async, rst_n=0): state=IDLE, grant=0, last_grant=0, beat_cnt=0, len_err=0.
  - All valid/ready outputs are 0 immediately on reset, independent of clk.
  - Any burst in flight is abandoned. Memory-side cleanup is the system's responsibility.
- IDLE:
  - Only m0 requesting: grant<=0.
  - Only m1 requesting: grant<=1.
  - Both requesting: grant <= ~last_grant. With last_grant=0 after reset, the first tie goes to m1 (d_cache).
  - Any request moves to ADDR, latches the owner's arlen into len_reg, and clears beat_cnt.
  - No requests: stay in IDLE.
- ADDR:
  - s_arvalid=1; s_araddr/s_arlen/s_arid come combinationally from the granted requester's inputs.
  - m{grant}_arready = s_arready; the other arready is 0.
  - On s_arready: last_grant<=grant, go to DATA.
  - Requesters must hold arvalid and payload stable until arready (AXI rule). Dropping arvalid in ADDR is illegal and not checked.
- DATA:
  - m{grant}_rvalid = s_rvalid; the other rvalid is 0.
  - s_rready = m{grant}_rready.
  - Each handshake (s_rvalid & s_rready) increments beat_cnt.
  - Burst end is the handshake where s_rlast=1 OR beat_cnt+1 == len_reg.
  - If exactly one of those two is true at burst end, set len_err.
  - At burst end, go to IDLE.
- Outside DATA: s_rready=0 and both m*_rvalid=0.
- m_rdata = s_rdata at all times.
- Latency:
  - Request in IDLE produces s_arvalid on the next cycle.
  - After a burst ends there is one IDLE bubble cycle before the next grant.
  - Minimum burst occupancy is 1 + 1 + len cycles.
- A request arriving during ADDR/DATA waits; it is arbitrated in the next IDLE.
- Fairness: if both requesters continuously request, grants strictly alternate.
- A new request from the current owner may not start until the burst end.
- grant holds its value in IDLE when there are no requests.
- beat_cnt is LEN_WIDTH bits and never wraps, because len ≤ 16.

Optional Feature:
- Macro MEM_READ_ARB_PERF_EN.
- When defined, adds four 32-bit output counters, cleared by reset and saturating at all-ones:
  - perf_grants0, perf_grants1: incremented on each AR handshake per owner.
  - perf_wait0, perf_wait1: incremented on each cycle requester N has arvalid=1 while not in ADDR with grant==N.
- When not defined, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- m0 only, addr 0x0001040, len 4, s_arready immediate, 4 beats with s_rlast on the 4th → s_arvalid the cycle after the request with s_arid=m0_arid; m0_rvalid 4×, m1_rvalid never; busy drops after the last beat; len_err=0.
- m0 and m1 assert in the same cycle after reset → m1 is granted first, m0 second; the second s_arvalid appears exactly 1 cycle after the first burst's last beat.
- Both requesters held high for 6 bursts → grant sequence is 1,0,1,0,1,0.
- s_arready held low for 5 cycles, then s_rvalid with 2-cycle gaps and m1_rready toggling → no beat is lost or duplicated; s_rready tracks m1_rready only in DATA.
- Assert rst_n=0 asynchronously mid-DATA after beat 2 of 4 → all valid/ready outputs drop before the next clk edge; state is IDLE and len_err=0 after release.
- len=4 but s_rlast on beat 3 → burst ends on beat 3 and len_err=1 stays set until reset. With MEM_READ_ARB_PERF_EN, perf_grants counts match the number of issued bursts.
